// File: rtl/line_buffer_reader_pkg.sv
// Shared types and constants for the scanline buffer read master.
package line_buffer_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } lbr_state_t;

  // Skid FIFO depth; this is also the total read credit available.
  localparam logic [1:0] FIFO_DEPTH = 2'd2;

endpackage

// File: rtl/line_buffer_reader_pixel_skid_fifo.sv
// Two-entry pixel FIFO between the buffer read port and the downstream handshake.
module pixel_skid_fifo #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head,
  output logic [1:0]            count
);

  logic [DATA_WIDTH-1:0] mem [2];
  logic                  wr_ptr;
  logic                  rd_ptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/line_buffer_reader.sv
// Scanline buffer read master: fetches 0..len-1, streams with horizontal pixel repeat.
//   state    | meaning
//   ST_IDLE  | waiting for start
//   ST_FETCH | issuing reads while credits remain
//   ST_DRAIN | all reads issued, emptying the FIFO
//   ST_DONE  | line_done pulse, back to idle
module line_buffer_reader
  import line_buffer_reader_pkg::*;
#(
  parameter int DATA_WIDTH        = 16,
  parameter int BUFFER_ADDR_WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [BUFFER_ADDR_WIDTH:0]   line_len,
  input  logic [1:0]                   scale,
  output logic [BUFFER_ADDR_WIDTH-1:0] buf_rd_addr,
  input  logic [DATA_WIDTH-1:0]        buf_rd_data,
  output logic [DATA_WIDTH-1:0]        px_data,
  output logic                         px_valid,
  input  logic                         px_ready,
  output logic                         busy,
  output logic                         line_done
);

  localparam logic [BUFFER_ADDR_WIDTH:0] IDX_ONE = {{BUFFER_ADDR_WIDTH{1'b0}}, 1'b1};

  lbr_state_t                 state;
  lbr_state_t                 state_nxt;
  logic [BUFFER_ADDR_WIDTH:0] len_q;
  logic [BUFFER_ADDR_WIDTH:0] idx;
  logic [1:0]                 scale_q;
  logic [1:0]                 rep;
  logic [1:0]                 fifo_count;
  logic [DATA_WIDTH-1:0]      fifo_head;
  logic                       accept_start;
  logic                       issue;
  logic                       last_issue;
  logic                       beat;
  logic                       pop;

  assign last_issue = (idx + IDX_ONE) == len_q;
  assign beat       = px_valid && px_ready;
  assign pop        = beat && (rep == scale_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // The buffer answers within the issue cycle, so a read is pushed at the
  // same edge that retires it; credits therefore reduce to free FIFO slots.
  always_comb begin
    state_nxt    = state;
    accept_start = 1'b0;
    issue        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          accept_start = 1'b1;
          state_nxt    = (line_len == '0) ? ST_DONE : ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (fifo_count < FIFO_DEPTH) begin
          issue = 1'b1;
          if (last_issue) begin
            state_nxt = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if ((fifo_count == 2'd0) || ((fifo_count == 2'd1) && pop)) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      len_q   <= '0;
      scale_q <= 2'd0;
      idx     <= '0;
      rep     <= 2'd0;
    end else if (accept_start) begin
      len_q   <= line_len;
      scale_q <= scale;
      idx     <= '0;
      rep     <= 2'd0;
    end else begin
      // Hold on the final word so the address never wraps inside a line.
      if (issue && !last_issue) begin
        idx <= idx + IDX_ONE;
      end else if (state == ST_DONE) begin
        idx <= '0;
      end
      if (beat) begin
        rep <= pop ? 2'd0 : rep + 2'd1;
      end
    end
  end

  pixel_skid_fifo #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (issue),
    .push_data(buf_rd_data),
    .pop      (pop),
    .head     (fifo_head),
    .count    (fifo_count)
  );

  assign buf_rd_addr = idx[BUFFER_ADDR_WIDTH-1:0];
  assign px_data     = fifo_head;
  assign px_valid    = fifo_count != 2'd0;
  assign busy        = state != ST_IDLE;
  assign line_done   = state == ST_DONE;

endmodule

// File: tb/tb_line_buffer_reader.sv
// Bench for line_buffer_reader: buffer model, scoreboard queue, table of line vectors.
module tb_line_buffer_reader;
  localparam int DW  = 16;
  localparam int BAW = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic [BAW:0]   line_len;
  logic [1:0]     scale;
  logic [BAW-1:0] buf_rd_addr;
  logic [DW-1:0]  buf_rd_data;
  logic [DW-1:0]  px_data;
  logic           px_valid;
  logic           px_ready;
  logic           busy;
  logic           line_done;

  always #5 clk = ~clk;

  line_buffer_reader #(.DATA_WIDTH(DW), .BUFFER_ADDR_WIDTH(BAW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .line_len   (line_len),
    .scale      (scale),
    .buf_rd_addr(buf_rd_addr),
    .buf_rd_data(buf_rd_data),
    .px_data    (px_data),
    .px_valid   (px_valid),
    .px_ready   (px_ready),
    .busy       (busy),
    .line_done  (line_done)
  );

  logic [DW-1:0] mem [256];
  always @(negedge clk) buf_rd_data <= mem[buf_rd_addr];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  int ready_mode = 0;
  int rphase = 0;
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      1:       px_ready = (rphase % 3 == 0);
      2:       px_ready = 1'($urandom_range(0, 1));
      default: px_ready = 1'b1;
    endcase
    rphase = rphase + 1;
  end

  logic [DW-1:0] exp_q[$];
  bit            mon_en = 1'b0;
  bit            stall_prev = 1'b0;
  logic [DW-1:0] held;
  int first_valid, last_beat, done_cyc, beats, cur_scale, done_addr;
  bit occ_bad;
  logic post_busy, post_done;

  always @(negedge clk) begin
    if (mon_en) begin
      if (stall_prev) begin
        check("stall_valid", 32'(px_valid), 32'(1));
        check("stall_data", 32'(px_data), 32'(held));
      end
      if (px_valid && first_valid < 0) first_valid = cyc;
      if (px_valid && px_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 32'(px_data), 32'hFFFF_FFFF);
        end else begin
          logic [DW-1:0] e;
          e = exp_q.pop_front();
          check("beat_data", 32'(px_data), 32'(e));
        end
        beats++;
        last_beat = cyc;
      end
      stall_prev = px_valid && !px_ready;
      held = px_data;
      if (busy && (int'(buf_rd_addr) - beats / (cur_scale + 1) > 2)) occ_bad = 1'b1;
      if (line_done && done_cyc < 0) begin
        done_cyc  = cyc;
        done_addr = int'(buf_rd_addr);
      end
      if (done_cyc >= 0 && cyc == done_cyc + 1) begin
        post_busy = busy;
        post_done = line_done;
      end
    end
  end

  task automatic begin_line(input int len, input int sc, input int mode);
    @(posedge clk); #1;
    ready_mode  = mode;
    rphase      = 0;
    line_len    = len[BAW:0];
    scale       = sc[1:0];
    first_valid = -1;
    last_beat   = -1;
    done_cyc    = -1;
    done_addr   = -1;
    beats       = 0;
    occ_bad     = 1'b0;
    stall_prev  = 1'b0;
    cur_scale   = sc;
    post_busy   = 1'b1;
    post_done   = 1'b1;
    for (int i = 0; i < len; i++)
      for (int r = 0; r <= sc; r++)
        exp_q.push_back(16'(16'hA000 + i));
    start  = 1'b1;
    mon_en = 1'b1;
  endtask

  task automatic run_line(input int len, input int sc, input int mode, input int exp_beats,
                          input bit contig);
    int start_cyc;
    int n;
    int exp_addr;
    begin_line(len, sc, mode);
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (done_cyc < 0 && n < exp_beats * 4 + 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("line_done_seen", 32'(done_cyc >= 0), 32'(1));
    repeat (3) @(posedge clk);
    #1;
    exp_addr = (len == 0) ? 0 : len - 1;
    check("beat_count", 32'(beats), 32'(exp_beats));
    check("queue_empty", 32'(exp_q.size()), 32'(0));
    check("addr_at_done", 32'(done_addr), 32'(exp_addr));
    check("busy_after_done", 32'(post_busy), 32'(0));
    check("done_one_cycle", 32'(post_done), 32'(0));
    check("outstanding_le2", 32'(occ_bad), 32'(0));
    if (len == 0) begin
      check("no_valid_len0", 32'(first_valid < 0), 32'(1));
      check("done_latency_len0", 32'(done_cyc - start_cyc), 32'(1));
    end else begin
      check("first_valid_latency", 32'(first_valid - start_cyc), 32'(2));
      check("done_after_last", 32'(done_cyc - last_beat), 32'(1));
      if (contig) check("no_gaps", 32'(last_beat - first_valid), 32'(exp_beats - 1));
    end
    mon_en = 1'b0;
    exp_q.delete();
  endtask

  task automatic wait_beats(input int n, input string name);
    int k;
    k = 0;
    while (beats < n && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    check(name, 32'(beats >= n), 32'(1));
  endtask

  typedef struct {
    int len;
    int sc;
    int mode;
    int beats;
    bit contig;
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs[0] = '{4,   0, 0, 4,   1'b1};
    vecs[1] = '{3,   3, 0, 12,  1'b1};
    vecs[2] = '{8,   0, 1, 8,   1'b0};
    vecs[3] = '{0,   0, 0, 0,   1'b0};
    vecs[4] = '{256, 1, 0, 512, 1'b1};
    vecs[5] = '{1,   2, 0, 3,   1'b1};
    vecs[6] = '{5,   1, 2, 10,  1'b0};

    for (int i = 0; i < 256; i++) mem[i] = 16'(16'hA000 + i);
    reset    = 1'b1;
    start    = 1'b0;
    line_len = '0;
    scale    = 2'd0;
    px_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_addr", 32'(buf_rd_addr), 32'(0));
    check("rst_data", 32'(px_data), 32'(0));
    check("rst_valid", 32'(px_valid), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(line_done), 32'(0));

    for (int v = 0; v < 7; v++)
      run_line(vecs[v].len, vecs[v].sc, vecs[v].mode, vecs[v].beats, vecs[v].contig);

    // Mid-line start is ignored, then reset aborts the line.
    begin_line(16, 0, 0);
    @(posedge clk); #1;
    start = 1'b0;
    wait_beats(2, "t6_reach2");
    line_len = 9'd3;
    scale    = 2'd3;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_beats(5, "t6_reach5");
    mon_en = 1'b0;
    exp_q.delete();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("t6_rst_addr", 32'(buf_rd_addr), 32'(0));
    check("t6_rst_data", 32'(px_data), 32'(0));
    check("t6_rst_valid", 32'(px_valid), 32'(0));
    check("t6_rst_busy", 32'(busy), 32'(0));
    check("t6_rst_done", 32'(line_done), 32'(0));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t6_no_done_after_rst", 32'(line_done), 32'(0));
      check("t6_idle_after_rst", 32'(busy), 32'(0));
    end
    run_line(2, 0, 0, 2, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
